fram_burst_ctl: RTL
===================

# fram_burst_ctl

Parametrised fast-RAM cycle controller for the Playground 68030 board: decodes the fast-RAM window, drives per-bank chip selects and byte-lane strobes, and terminates cycles synchronously with STERM after a programmable number of wait states. It is the registered, multi-bank successor to the combinational zero-wait fast-RAM path in the system controller. It also optionally supports 68030 cache burst fills. It sits beside the system controller on the CPU bus and owns all fast-RAM timing.

## Interface
- BASE, 32'hFF80_0000, window base address; aligned to 2**REGION_BITS.
- REGION_BITS, 22, log2 of window size in bytes (4MB default).
- BANKS, 2, number of SRAM banks (power of 2, 1..8); bank index = ADDR[REGION_BITS-1 -: log2(BANKS)].
- WAIT_STATES, 1, CPU_CLK cycles inserted before each STERM (0..7).
- CPU_CLK  in  1  CPU clock (25MHz); the only clock, all state on rising edge.
- nRST  in  1  asynchronous, active-low reset.
- nAS  in  1  CPU address strobe.
- RnW  in  1  1 = read.
- SIZ  in  2  68030 transfer size (00 = long).
- FC  in  3  function code; only user/supervisor data/program spaces (FC1 xor FC0) are decoded.
- ADDR  in  32  CPU address.
- nCBREQ  in  1  CPU cache burst request.
- nFRAM_CS  out  BANKS  per-bank chip select, active-low.
- nFRAM_RD  out  1  output enable, all lanes.
- nFRAM_WR  out  4  byte-lane write strobes, [0] = D31:24.
- FRAM_LA  out  2  longword address A3:A2 to SRAM (burst counter).
- STERM  out  1  synchronous termination; active-high, external open-drain inverter.
- CBACK  out  1  burst acknowledge; active-high, external open-drain inverter.

## Operation
- States: IDLE, WAIT, TERM, DONE.
- IDLE: on an edge with nAS=0, normal space and ADDR[31:REGION_BITS]==BASE[31:REGION_BITS], capture bank, RnW, SIZ, ADDR[1:0] and ADDR[3:2]. Load the wait counter with WAIT_STATES. Go to WAIT, or directly to TERM if WAIT_STATES=0.
- On capture: assert nFRAM_CS[bank]. Assert nFRAM_RD for a read, or the nFRAM_WR lanes for a write, per 68030 Table 7-4:
  - byte: one lane at ADDR[1:0];
  - word: lanes ADDR[1:0]..min(ADDR[1:0]+1,3);
  - 3-byte: three lanes, clipped at lane 3;
  - long: lanes ADDR[1:0]..3.
- WAIT: decrement the counter each cycle; go to TERM when it reaches 1.
- TERM: STERM=1 for exactly one cycle. Then:
  - go to DONE, or
  - in a burst with beats remaining, go back to WAIT/TERM with FRAM_LA+1 (mod 4, wraps 3→0).
- DONE: all strobes and CS inactive; wait for nAS=1, then IDLE. A new cycle is never captured in DONE.
- nAS negating in WAIT or TERM (aborted cycle): go to IDLE on the next edge, deassert everything, and emit no STERM.
- Addresses outside the window, or CPU/reserved space: no output changes.
- Reset values: nFRAM_CS all 1, nFRAM_RD=1, nFRAM_WR=4'hF, FRAM_LA=0, STERM=0, CBACK=0, state IDLE. Reset asserted mid-cycle forces these values immediately.

## Timing
- Capture edge E0: CS and strobes are valid after E0 (registered, glitch-free).
- STERM is high between edge E0+WAIT_STATES and edge E0+WAIT_STATES+1; the CPU samples it at E0+WAIT_STATES+1.
- First-beat latency is 1+WAIT_STATES clocks (WAIT_STATES=0 gives a 2-clock synchronous cycle).
- Write strobes deassert on the edge after STERM, so data hold is covered by the CPU's S-state hold.
- Burst beats after the first: each costs WAIT_STATES+1 clocks. FRAM_LA changes on the edge ending each TERM.

## Configuration
- FRAM_BURST_EN defined:
  - A read capture with nCBREQ=0 starts a burst; CBACK=1 from capture through the final beat's TERM.
  - After each TERM, continue if fewer than 4 beats are done and nCBREQ=0; otherwise go to DONE.
  - Writes never burst.
- FRAM_BURST_EN undefined: nCBREQ is ignored, CBACK is tied 0, FRAM_LA = captured ADDR[3:2], and every cycle is a single beat. Ports are identical in both builds.

## Test plan
- Long read at $FF80_0010, FC=5, defaults: nFRAM_CS=2'b10, nFRAM_RD=0, FRAM_LA=0. STERM is high only in the 2nd clock after capture. DONE holds until nAS=1.
- Byte write at $FFA0_0003 (bank 1), SIZ=01: nFRAM_WR=4'b1110 and nFRAM_CS=2'b01 for 2 clocks, then STERM for 1 clock.
- Word write at $FF80_0002 with WAIT_STATES=0: nFRAM_WR=4'b1100 and STERM in the first clock after capture.
- Abort: read at $FF80_0000 with nAS negated before STERM. Required: no STERM, all outputs inactive next edge, and an immediate next cycle is captured normally.
- FC=7 cycle at $FF80_0000, and FC=5 read at $FF7F_FFFC: all outputs stay at reset values.
- FRAM_BURST_EN build: read at $FF80_0008 with nCBREQ=0. Required: 4 STERM pulses 2 clocks apart, FRAM_LA = 2,3,0,1, and CBACK high throughout. Negating nCBREQ after beat 2 ends the burst after 2 STERMs. Asserting nRST mid-burst returns all outputs to reset values asynchronously.

Source files
------------

// File: rtl/fram_burst_ctl_if.sv
// CPU-side bus bundle for the fast-RAM cycle controller: 68030 address/strobe
// inputs plus the SRAM strobes and synchronous termination outputs.
interface fram_burst_ctl_if #(
  parameter int BANKS = 2
);
  logic             nAS;
  logic             RnW;
  logic [1:0]       SIZ;
  logic [2:0]       FC;
  logic [31:0]      ADDR;
  logic             nCBREQ;
  logic [BANKS-1:0] nFRAM_CS;
  logic             nFRAM_RD;
  // Ascending range: element [0] is lane D31:24, so a literal reads lane 0..3 left to right.
  logic [0:3]       nFRAM_WR;
  logic [1:0]       FRAM_LA;
  logic             STERM;
  logic             CBACK;

  modport master (
    output nAS, RnW, SIZ, FC, ADDR, nCBREQ,
    input  nFRAM_CS, nFRAM_RD, nFRAM_WR, FRAM_LA, STERM, CBACK
  );

  modport slave (
    input  nAS, RnW, SIZ, FC, ADDR, nCBREQ,
    output nFRAM_CS, nFRAM_RD, nFRAM_WR, FRAM_LA, STERM, CBACK
  );
endinterface

// File: rtl/fram_burst_ctl.sv
// Registered multi-bank fast-RAM controller with STERM termination after WAIT_STATES.
// Define FRAM_BURST_EN to enable 68030 cache burst fills (CBACK, 4-beat FRAM_LA walk).
module fram_burst_ctl #(
  parameter logic [31:0] BASE        = 32'hFF80_0000,
  parameter int          REGION_BITS = 22,
  parameter int          BANKS       = 2,
  parameter int          WAIT_STATES = 1
) (
  input  logic CPU_CLK,
  input  logic nRST,
  fram_burst_ctl_if.slave bus,
  output logic [1:0] dbgState
);

  localparam int BANK_BITS = (BANKS > 1) ? $clog2(BANKS) : 1;

  // Handshake: a cycle starts on the first edge seeing nAS=0 with a decoded address,
  // STERM is a one-clock pulse, and the controller only rearms after nAS returns high.
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, TERM = 2'd2, DONE = 2'd3} stateT;

  stateT                state, stateNext;
  logic [2:0]           waitCnt, cntNext;
  logic [BANK_BITS-1:0] bank, bankNext, bankSel;
  logic                 isRead, readNext;
  logic [0:3]           wrMask, wrMaskNext;
  logic [1:0]           la, laNext;
  logic                 burst, burstNext;
  logic [1:0]           beats, beatsNext;
  logic [BANKS-1:0]     nCsQ, nCsNext;
  logic                 nRdQ, nRdNext;
  logic [0:3]           nWrQ, nWrNext;
  logic                 stermQ, stermNext;
  logic                 cbackQ, cbackNext;
  logic                 hit, active;

  generate
    if (BANKS > 1) begin : gBankSel
      assign bankSel = bus.ADDR[REGION_BITS-1 -: BANK_BITS];
    end else begin : gSingleBank
      assign bankSel = '0;
    end
  endgenerate

  assign hit = !bus.nAS && (bus.FC[1] ^ bus.FC[0]) &&
               (bus.ADDR[31:REGION_BITS] == BASE[31:REGION_BITS]);

  // Active-low lane mask from the 68030 size/offset pair; lanes past 3 fall off the end.
  function automatic logic [0:3] laneMask(input logic [1:0] siz, input logic [1:0] a0);
    logic [2:0] lo, hi, idx;
    laneMask = '1;
    lo = {1'b0, a0};
    hi = lo + ((siz == 2'b00) ? 3'd4 : {1'b0, siz});
    for (int i = 0; i < 4; i++) begin
      idx = 3'(i);
      if (idx >= lo && idx < hi) laneMask[i] = 1'b0;
    end
  endfunction

  always_ff @(posedge CPU_CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      waitCnt <= '0;
      bank    <= '0;
      isRead  <= 1'b1;
      wrMask  <= '1;
      la      <= '0;
      burst   <= 1'b0;
      beats   <= '0;
      nCsQ    <= '1;
      nRdQ    <= 1'b1;
      nWrQ    <= '1;
      stermQ  <= 1'b0;
      cbackQ  <= 1'b0;
    end else begin
      state   <= stateNext;
      waitCnt <= cntNext;
      bank    <= bankNext;
      isRead  <= readNext;
      wrMask  <= wrMaskNext;
      la      <= laNext;
      burst   <= burstNext;
      beats   <= beatsNext;
      nCsQ    <= nCsNext;
      nRdQ    <= nRdNext;
      nWrQ    <= nWrNext;
      stermQ  <= stermNext;
      cbackQ  <= cbackNext;
    end
  end

  always_comb begin
    stateNext  = state;
    cntNext    = waitCnt;
    bankNext   = bank;
    readNext   = isRead;
    wrMaskNext = wrMask;
    laNext     = la;
    burstNext  = burst;
    beatsNext  = beats;
    case (state)
      IDLE: begin
        if (hit) begin
          bankNext   = bankSel;
          readNext   = bus.RnW;
          wrMaskNext = laneMask(bus.SIZ, bus.ADDR[1:0]);
          laNext     = bus.ADDR[3:2];
`ifdef FRAM_BURST_EN
          burstNext  = bus.RnW && !bus.nCBREQ;
`else
          burstNext  = 1'b0;
`endif
          beatsNext  = '0;
          cntNext    = 3'(WAIT_STATES);
          stateNext  = (WAIT_STATES == 0) ? TERM : WAIT;
        end
      end
      WAIT: begin
        cntNext = waitCnt - 3'd1;
        if (bus.nAS)              stateNext = IDLE;
        else if (waitCnt <= 3'd1) stateNext = TERM;
      end
      TERM: begin
        if (bus.nAS) begin
          stateNext = IDLE;
        end else if (burst && beats != 2'd3 && !bus.nCBREQ) begin
          beatsNext = beats + 2'd1;
          laNext    = la + 2'd1;
          cntNext   = 3'(WAIT_STATES);
          stateNext = (WAIT_STATES == 0) ? TERM : WAIT;
        end else begin
          stateNext = DONE;
        end
      end
      DONE: begin
        if (bus.nAS) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase

    // Outputs are registered from the next state so they change cleanly on the edge.
    active  = (stateNext == WAIT) || (stateNext == TERM);
    nCsNext = '1;
    if (active) nCsNext[bankNext] = 1'b0;
    nRdNext   = !(active && readNext);
    nWrNext   = (active && !readNext) ? wrMaskNext : 4'hF;
    stermNext = (stateNext == TERM);
    cbackNext = active && burstNext;
  end

  assign bus.nFRAM_CS = nCsQ;
  assign bus.nFRAM_RD = nRdQ;
  assign bus.nFRAM_WR = nWrQ;
  assign bus.FRAM_LA  = la;
  assign bus.STERM    = stermQ;
  assign dbgState     = state;

`ifdef FRAM_BURST_EN
  logic unusedBits;
  assign bus.CBACK  = cbackQ;
  assign unusedBits = ^bus.ADDR;
`else
  logic unusedBits;
  assign bus.CBACK  = 1'b0;
  assign unusedBits = ^{bus.ADDR, cbackQ};
`endif

endmodule
